ov7670_capture: RTL and testbench
=================================

// Module: ov7670_capture
// PURPOSE
// - Camera-side capture stage: samples OV7670 DVP bus (vref/href/d) on the camera pixel clock, pairs
//   RGB565 bytes, converts to RGB444, decimates in X/Y, drives write port A of buffer_mem (clka/wea/addra/dina).
// - Feeds the VGA readout path; replaces inline capture logic in the top level.
// PARAMETERS
// - SRC_W   640  active pixels per line from camera
// - SRC_H   480  active lines per frame
// - DEC_X   4    keep 1 of DEC_X pixels per line (col % DEC_X == 0)
// - DEC_Y   4    keep 1 of DEC_Y lines (row % DEC_Y == 0)
// - ADDR_W  17   write address width
// - DEPTH   (SRC_W/DEC_X)*(SRC_H/DEC_Y)  words per frame; writes at addr >= DEPTH suppressed
// PORTS
// - clk         in   1       camera pclk (IBUF'd); sole clock
// - reset       in   1       synchronous, active-high
// - capture_en  in   1       level; enables capture, sampled at frame boundaries
// - vref        in   1       camera VSYNC; high = vertical blanking
// - href        in   1       camera HREF; high = active bytes on d
// - d           in   8       camera data byte
// - we          out  1       write strobe to buffer_mem port A
// - addr        out  ADDR_W  write address
// - data        out  12      pixel {R[3:0],G[3:0],B[3:0]}
// - busy        out  1       high while in CAPTURE
// - frame_done  out  1       1-cycle pulse at end of each captured frame
// - frame_err   out  1       error status of last frame; updated with frame_done, held otherwise
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters, phase, byte latch 0. Reset mid-frame aborts instantly, no pulse.
// - Inputs registered once (vref_q, href_q, d_q); all decisions use registered copies; vref_q resets to 1.
// - States: IDLE -> SYNC when capture_en. SYNC -> CAPTURE on vref_q falling edge (needs prior vref_q=1);
//   on entry addr/row/col/phase=0, err=0. CAPTURE -> (capture_en ? SYNC : IDLE) on vref_q rising edge.
// - capture_en low in SYNC -> IDLE; low in CAPTURE -> frame completes normally, then IDLE.
// - CAPTURE, href_q=1: phase toggles each cycle. phase0: latch b0=d_q. phase1: pixel complete, col++.
// - Conversion (b0,b1 = RGB565 bytes): R=b0[7:4], G={b0[2:0],b1[7]}, B=b1[4:1].
// - Write on pixel complete iff col%DEC_X==0 and row%DEC_Y==0 and addr<DEPTH: we=1 next cycle with
//   data/addr; addr increments after the write. we high exactly 1 cycle per kept pixel.
// - Latency: byte1 on d at edge N -> we/data/addr valid after edge N+2.
// - addr would exceed DEPTH-1 -> write dropped, err=1; addr saturates at DEPTH.
// - href_q falling: col=0, phase=0; row++ if line held >=1 byte. phase=1 at fall (odd bytes) -> drop byte, err=1.
// - col reaching SRC_W within a line: further bytes ignored until href falls, err=1.
// - vref_q rising in CAPTURE: frame_done=1 one cycle; frame_err = err | (addr != DEPTH).
// - vref_q rising and href_q=1 same cycle: vref wins; pending pixel discarded.
// - col/row use modulo counters (wrap at DEC_X/DEC_Y) rather than division.
// STRUCTURE
// - cam_pkg: typedef enum cap_state_t {IDLE,SYNC,CAPTURE}; typedef rgb444_t; function rgb565_to_444.
// - Single module; no sub-module (edge detects and counters are inline).
// TESTING (bench params SRC_W=8 SRC_H=4 DEC_X=2 DEC_Y=2 DEPTH=8)
// - Reset held 3 cycles mid-stream -> we,addr,data,busy,frame_done,frame_err all 0; state IDLE.
// - Pixel bytes F8,1F -> data=F0F; bytes 07,E0 -> data=0F0; we 2 cycles after byte 2.
// - Full frame, byte pair = pixel index -> 8 writes, addr 0..7, cols 0/2/4/6 of rows 0/2; one frame_done, frame_err=0.
// - Frame with only 2 lines -> 4 writes, frame_done, frame_err=1.
// - Line with 15 bytes -> last byte dropped, no extra write, frame_err=1 at frame_done.
// - capture_en dropped mid-frame -> frame finishes (8 writes, frame_done), next frame: no we, busy=0.

Source files
------------

// File: rtl/ov7670_capture_pkg.sv
// Shared types and helpers for the OV7670 capture stage: FSM states, the
// RGB444 pixel word and the RGB565 -> RGB444 reduction.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CAPTURE
  } cap_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // b0 = {R5,G6[5:3]}, b1 = {G6[2:0],B5}; keep the top 4 bits of each channel.
  function automatic rgb444_t rgb565_to_444(input logic [7:0] b0, input logic [7:0] b1);
    rgb444_t p;
    p.r = b0[7:4];
    p.g = {b0[2:0], b1[7]};
    p.b = b1[4:1];
    return p;
  endfunction

  // Counter width for a modulo-n counter; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera DVP inputs plus the frame-buffer write port of the capture stage.
// master = capture stage, slave = camera/buffer side.
interface ov7670_capture_if #(
  parameter int ADDR_W = 17
);
  logic              vref;
  logic              href;
  logic [7:0]        d;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       data;

  modport master (input vref, href, d, output we, addr, data);
  modport slave  (output vref, href, d, input we, addr, data);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: registers the DVP bus, pairs RGB565 bytes into RGB444 pixels,
// decimates in X/Y and writes kept pixels to the frame buffer (byte1 -> we: 2 edges).
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int DEC_X  = 4,
  parameter int DEC_Y  = 4,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = (SRC_W / DEC_X) * (SRC_H / DEC_Y)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_en,
  ov7670_capture_if.master bus,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CW  = $clog2(SRC_W + 1);
  localparam int CXW = idx_width(DEC_X);
  localparam int CYW = idx_width(DEC_Y);

  localparam logic [CW-1:0]     COL_END  = CW'(SRC_W);
  localparam logic [CXW-1:0]    CX_LAST  = CXW'(DEC_X - 1);
  localparam logic [CYW-1:0]    CY_LAST  = CYW'(DEC_Y - 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH);

  cap_state_t state, state_nxt;

  logic              vref_q, vref_p, href_q, href_p;
  logic [7:0]        d_q;
  logic              vref_rise, vref_fall, href_fall;
  logic              start, finish;

  logic              phase;
  logic              line_any;
  logic              err;
  logic [7:0]        b0;
  logic [CW-1:0]     col;
  logic [CXW-1:0]    col_mod;
  logic [CYW-1:0]    row_mod;
  logic [ADDR_W-1:0] waddr;

  logic              pix_vld;
  rgb444_t           pix_dat;

  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  rgb444_t           data_r;

  assign bus.we   = we_r;
  assign bus.addr = addr_r;
  assign bus.data = data_r;
  assign busy     = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    vref_rise = vref_q & ~vref_p;
    vref_fall = ~vref_q & vref_p;
    href_fall = ~href_q & href_p;
    case (state)
      IDLE: begin
        if (capture_en) state_nxt = SYNC;
      end
      SYNC: begin
        if (!capture_en) begin
          state_nxt = IDLE;
        end else if (vref_fall) begin
          state_nxt = CAPTURE;
          start     = 1'b1;
        end
      end
      CAPTURE: begin
        // capture_en only matters here once the frame has ended
        if (vref_rise) begin
          finish    = 1'b1;
          state_nxt = capture_en ? SYNC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vref_q     <= 1'b1;
      vref_p     <= 1'b1;
      href_q     <= 1'b0;
      href_p     <= 1'b0;
      d_q        <= '0;
      phase      <= 1'b0;
      line_any   <= 1'b0;
      err        <= 1'b0;
      b0         <= '0;
      col        <= '0;
      col_mod    <= '0;
      row_mod    <= '0;
      waddr      <= '0;
      pix_vld    <= 1'b0;
      pix_dat    <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      data_r     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      vref_q     <= bus.vref;
      vref_p     <= vref_q;
      href_q     <= bus.href;
      href_p     <= href_q;
      d_q        <= bus.d;
      we_r       <= 1'b0;
      frame_done <= 1'b0;
      pix_vld    <= 1'b0;

      if (start) begin
        phase    <= 1'b0;
        line_any <= 1'b0;
        err      <= 1'b0;
        col      <= '0;
        col_mod  <= '0;
        row_mod  <= '0;
        waddr    <= '0;
      end else if (finish) begin
        // end of frame takes priority over any byte or staged pixel this cycle
        frame_done <= 1'b1;
        frame_err  <= err | (waddr != ADDR_END);
      end else if (state == CAPTURE) begin
        if (pix_vld) begin
          if (waddr < ADDR_END) begin
            we_r   <= 1'b1;
            addr_r <= waddr;
            data_r <= pix_dat;
            waddr  <= waddr + 1'b1;
          end else begin
            err <= 1'b1;
          end
        end

        if (href_q) begin
          line_any <= 1'b1;
          if (col == COL_END) begin
            err <= 1'b1;
          end else if (!phase) begin
            b0    <= d_q;
            phase <= 1'b1;
          end else begin
            phase   <= 1'b0;
            col     <= col + 1'b1;
            col_mod <= (col_mod == CX_LAST) ? '0 : col_mod + 1'b1;
            pix_vld <= (col_mod == '0) && (row_mod == '0);
            pix_dat <= rgb565_to_444(b0, d_q);
          end
        end else if (href_fall) begin
          col      <= '0;
          col_mod  <= '0;
          phase    <= 1'b0;
          line_any <= 1'b0;
          if (line_any) row_mod <= (row_mod == CY_LAST) ? '0 : row_mod + 1'b1;
          if (phase) err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed + randomized bench for ov7670_capture on a reduced 8x4 source, 2x2 decimation.
module tb_ov7670_capture;
  import cam_pkg::*;

  localparam int SRC_W  = 8;
  localparam int SRC_H  = 4;
  localparam int DEC_X  = 2;
  localparam int DEC_Y  = 2;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 17;
  localparam int MAXL   = 8;
  localparam int MAXB   = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic capture_en = 1'b0;
  logic busy, frame_done, frame_err;

  ov7670_capture_if #(.ADDR_W(ADDR_W)) bus ();

  ov7670_capture #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DEC_X(DEC_X), .DEC_Y(DEC_Y),
    .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .bus(bus),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   obs_addr[$], obs_data[$], obs_cyc[$];
  int   done_cnt = 0;
  logic last_err = 1'b0;
  bit   busy_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      obs_addr.push_back(int'(bus.addr));
      obs_data.push_back(int'(bus.data));
      obs_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      last_err = frame_err;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  logic [7:0] ln_byte[MAXL][MAXB];
  int         ln_len[MAXL];
  int         drv_cyc[MAXL][MAXB];
  int         n_lines;
  int         drop_line = -1;

  int exp_addr[$], exp_data[$], exp_cyc[$];
  bit exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int conv(input int b0, input int b1);
    int r, g, b;
    r = b0 / 16;
    g = (b0 % 8) * 2 + b1 / 128;
    b = (b1 / 2) % 16;
    return r * 256 + g * 16 + b;
  endfunction

  // Pixel p of the frame carries the 16-bit pair value p.
  task automatic fill_index();
    n_lines = SRC_H;
    for (int l = 0; l < MAXL; l++) begin
      ln_len[l] = 2 * SRC_W;
      for (int c = 0; c < MAXB / 2; c++) begin
        ln_byte[l][2*c]   = 8'(((l * SRC_W + c) >> 8) & 255);
        ln_byte[l][2*c+1] = 8'((l * SRC_W + c) & 255);
      end
    end
  endtask

  task automatic fill_random(input int nl);
    int r;
    n_lines = nl;
    for (int l = 0; l < MAXL; l++) begin
      r = $urandom_range(0, 9);
      ln_len[l] = (r == 0) ? 2 * SRC_W - 1 : (r == 1) ? 2 * SRC_W + 1 :
                  (r == 2) ? int'($urandom_range(2, 14)) : 2 * SRC_W;
      for (int b = 0; b < MAXB; b++) ln_byte[l][b] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run_frame();
    bus.vref = 1'b1;
    bus.href = 1'b0;
    repeat (4) @(negedge clk);
    bus.vref = 1'b0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < n_lines; l++) begin
      if (l == drop_line) capture_en = 1'b0;
      for (int b = 0; b < ln_len[l]; b++) begin
        bus.href = 1'b1;
        bus.d = ln_byte[l][b];
        drv_cyc[l][b] = cyc;
        @(negedge clk);
      end
      bus.href = 1'b0;
      bus.d = 8'($urandom_range(0, 255));
      repeat (3) @(negedge clk);
    end
    bus.vref = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Reference: walk the frame line by line, pair bytes, keep the decimated grid,
  // fill addresses in order up to DEPTH.
  task automatic build_expect();
    int row, addr, npix;
    row = 0;
    addr = 0;
    exp_err = 1'b0;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    for (int l = 0; l < n_lines; l++) begin
      if (ln_len[l] == 0) continue;
      if (ln_len[l] > 2 * SRC_W || ln_len[l] % 2 == 1) exp_err = 1'b1;
      npix = (ln_len[l] / 2 < SRC_W) ? ln_len[l] / 2 : SRC_W;
      for (int c = 0; c < npix; c++) begin
        if (c % DEC_X == 0 && row % DEC_Y == 0) begin
          if (addr < DEPTH) begin
            exp_addr.push_back(addr);
            exp_data.push_back(conv(int'(ln_byte[l][2*c]), int'(ln_byte[l][2*c+1])));
            exp_cyc.push_back(drv_cyc[l][2*c+1] + 3);
            addr++;
          end else begin
            exp_err = 1'b1;
          end
        end
      end
      row++;
    end
    if (addr != DEPTH) exp_err = 1'b1;
  endtask

  task automatic run_and_check(input string tag);
    int d0;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    d0 = done_cnt;
    run_frame();
    build_expect();
    check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < obs_addr.size()) begin
        check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
        check({tag, "_data"}, obs_data[i], exp_data[i]);
        check({tag, "_wcyc"}, obs_cyc[i], exp_cyc[i]);
      end
    end
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_err"}, last_err, exp_err);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"}, bus.we, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_data"}, bus.data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_state"}, dut.state, IDLE);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int d0;
    bus.vref = 1'b1;
    bus.href = 1'b0;
    bus.d = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("rst0");
    reset = 1'b0;
    capture_en = 1'b1;

    // Directed colours: pixel at col 0 and col 2 of row 0
    fill_index();
    ln_byte[0][0] = 8'hF8; ln_byte[0][1] = 8'h1F;
    ln_byte[0][4] = 8'h07; ln_byte[0][5] = 8'hE0;
    run_and_check("px");
    check("px_f0f", (obs_data.size() > 0) ? obs_data[0] : -1, 32'hF0F);
    check("px_0f0", (obs_data.size() > 1) ? obs_data[1] : -1, 32'h0F0);

    fill_index();
    run_and_check("idx");
    check("idx_count8", obs_addr.size(), 8);
    check("idx_noerr", last_err, 0);

    fill_index();
    n_lines = 2;
    run_and_check("two");
    check("two_count4", obs_addr.size(), 4);
    check("two_err", last_err, 1);

    fill_index();
    ln_len[0] = 15;
    run_and_check("odd");
    check("odd_err", last_err, 1);

    for (int k = 0; k < 12; k++) begin
      fill_random(int'($urandom_range(2, 6)));
      run_and_check("rnd");
    end

    // capture_en dropped mid-frame: frame completes, next frame ignored
    fill_index();
    drop_line = 2;
    run_and_check("drop");
    drop_line = -1;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    busy_seen = 1'b0;
    d0 = done_cnt;
    fill_index();
    run_frame();
    check("off_nwrites", obs_addr.size(), 0);
    check("off_done", done_cnt - d0, 0);
    check("off_busy", busy_seen, 0);

    // Reset held 3 cycles in the middle of an active line
    capture_en = 1'b1;
    d0 = done_cnt;
    bus.vref = 1'b1;
    repeat (4) @(negedge clk);
    bus.vref = 1'b0;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      bus.href = 1'b1;
      bus.d = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    reset = 1'b1;
    repeat (3) begin
      bus.d = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    check_reset_state("rstmid");
    reset = 1'b0;
    bus.href = 1'b0;
    bus.vref = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_nodone", done_cnt - d0, 0);

    fill_index();
    run_and_check("post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
